paddle_ctrl: RTL and testbench

//  Consumes the 400 Hz strobe from the clock divider. Moves one air-hockey paddle from four raw push-buttons.

---
 rtl/airhockey_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/paddle_ctrl.sv | 142 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/airhockey_pkg.sv
// Shared constants for the air-hockey game: coordinate width, table
// geometry and the bit positions of the paddle button vector.
package airhockey_pkg;

  // Width of every screen coordinate register
  localparam int POS_W = 10;

  // Table geometry in pixels; MID_Y is the centre line between halves
  localparam int TABLE_W = 640;
  localparam int TABLE_H = 480;
  localparam int MID_Y   = 240;

  // Bit positions inside a 4-bit button vector
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int NUM_BTN   = 4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchronizer followed by a
// tick-paced debounce counter. A new raw level is accepted only after it
// has differed from the current stable level on DEB_TICKS consecutive
// ticks; any tick that sees the levels agree restarts the count.
module btn_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic tick_en,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  logic             raw_s1;
  logic             raw_s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button level into the clk50 domain
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      raw_s1 <= 1'b0;
      raw_s2 <= 1'b0;
    end else begin
      raw_s1 <= raw;
      raw_s2 <= raw_s1;
    end
  end

  // Count consecutive differing ticks; accept the new level on the last one
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (tick_en) begin
      if (raw_s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_TICKS - 1)) begin
        stable <= raw_s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: turns four raw buttons into a clamped paddle position
// that advances once per 400 Hz tick. Outputs are registered and feed the
// collision stage and the renderer.
//
// Output strobe semantics: update is a single-cycle pulse, high in exactly
// the cycle in which pos_x/pos_y first show a new value. There is no
// back-pressure; consumers must sample position while update is high or
// read the held registers later.
module paddle_ctrl
  import airhockey_pkg::*;
#(
  parameter int POS_W     = airhockey_pkg::POS_W,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = airhockey_pkg::TABLE_W - 1,
  parameter int Y_MIN     = airhockey_pkg::MID_Y,
  parameter int Y_MAX     = airhockey_pkg::TABLE_H - 1,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 400,
  parameter int STEP      = 2,
  parameter int DEB_TICKS = 4
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             tick400,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             freeze,
  input  logic             recenter,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             moving,
  output logic             update
);

  logic               tick_s1;
  logic               tick_s2;
  logic               tick_prev;
  logic               tick_en;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_stable;
  logic [POS_W-1:0]   next_x;
  logic [POS_W-1:0]   next_y;
  logic               next_moving;
  logic               pos_changed;

  // One step along an axis with saturation at [lo, hi]; the sum is formed
  // one bit wider so a step past the top bound cannot wrap around.
  function automatic logic [POS_W-1:0] step_axis(
    input logic [POS_W-1:0] pos,
    input logic             inc,
    input logic             dec,
    input logic [POS_W-1:0] lo,
    input logic [POS_W-1:0] hi
  );
    logic [POS_W:0] sum;
    logic [POS_W:0] lo_plus;
    sum       = {1'b0, pos} + (POS_W+1)'(STEP);
    lo_plus   = {1'b0, lo} + (POS_W+1)'(STEP);
    step_axis = pos;
    if (inc && !dec) begin
      step_axis = (sum > {1'b0, hi}) ? hi : sum[POS_W-1:0];
    end else if (dec && !inc) begin
      step_axis = ({1'b0, pos} < lo_plus) ? lo : pos - POS_W'(STEP);
    end
  endfunction

  assign btn_raw[BTN_UP]    = btn_up;
  assign btn_raw[BTN_DOWN]  = btn_down;
  assign btn_raw[BTN_LEFT]  = btn_left;
  assign btn_raw[BTN_RIGHT] = btn_right;

  // Debounced level per button, all paced by the same tick
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(
      .DEB_TICKS (DEB_TICKS)
    ) u_debounce (
      .clk50   (clk50),
      .rst_n   (rst_n),
      .tick_en (tick_en),
      .raw     (btn_raw[b]),
      .stable  (btn_stable[b])
    );
  end

  // Synchronize the divider strobe and remember its previous level
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      tick_s1   <= tick400;
      tick_s2   <= tick_s1;
      tick_prev <= tick_s2;
    end
  end

  // Rising edge of the synced strobe, so strobe width does not matter
  assign tick_en = tick_s2 & ~tick_prev;

  // Next position and motion flag; recenter overrides any tick motion
  always_comb begin
    next_x      = pos_x;
    next_y      = pos_y;
    next_moving = moving;
    if (recenter) begin
      next_x      = POS_W'(X_INIT);
      next_y      = POS_W'(Y_INIT);
      next_moving = 1'b0;
    end else if (tick_en) begin
      if (freeze) begin
        next_moving = 1'b0;
      end else begin
        next_x = step_axis(pos_x, btn_stable[BTN_RIGHT], btn_stable[BTN_LEFT],
                           POS_W'(X_MIN), POS_W'(X_MAX));
        next_y = step_axis(pos_y, btn_stable[BTN_DOWN], btn_stable[BTN_UP],
                           POS_W'(Y_MIN), POS_W'(Y_MAX));
        next_moving = (next_x != pos_x) || (next_y != pos_y);
      end
    end
  end

  assign pos_changed = (next_x != pos_x) || (next_y != pos_y);

  // Position, motion flag and the change strobe that accompanies new values
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pos_x  <= POS_W'(X_INIT);
      pos_y  <= POS_W'(Y_INIT);
      moving <= 1'b0;
      update <= 1'b0;
    end else begin
      pos_x  <= next_x;
      pos_y  <= next_y;
      moving <= next_moving;
      update <= pos_changed;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: a behavioural model pushes the expected
// position/moving/update count per tick into a queue; each entry is popped
// and checked once the DUT has had time to respond.
module tb_paddle_ctrl;
  import airhockey_pkg::*;

  localparam int EX_X_MAX  = 639;
  localparam int EX_Y_MIN  = 240;
  localparam int EX_Y_MAX  = 479;
  localparam int EX_X_MIN  = 0;
  localparam int EX_X_INIT = 320;
  localparam int EX_Y_INIT = 400;
  localparam int EX_STEP   = 2;
  localparam int EX_DEB    = 4;

  // ---------------- clock / reset ----------------
  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic       rst_n;
  logic       tick400;
  logic [3:0] btn;
  logic       freeze;
  logic       recenter;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       moving;
  logic       update;

  paddle_ctrl dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .tick400   (tick400),
    .btn_up    (btn[BTN_UP]),
    .btn_down  (btn[BTN_DOWN]),
    .btn_left  (btn[BTN_LEFT]),
    .btn_right (btn[BTN_RIGHT]),
    .freeze    (freeze),
    .recenter  (recenter),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .moving    (moving),
    .update    (update)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          upd_cnt = 0;
  int          consec_cnt = 0;
  logic        upd_prev = 1'b0;
  logic [22:0] exp_q[$];

  // model state
  int       m_x;
  int       m_y;
  bit [3:0] m_stable;
  int       m_cnt[4];

  // update pulse monitor, sampled away from the active edge
  always @(negedge clk50) begin
    if (update === 1'b1) begin
      upd_cnt++;
      if (upd_prev === 1'b1) consec_cnt++;
    end
    upd_prev = update;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] pack(input int x, input int y, input bit mov, input int u);
    logic [9:0] xs;
    logic [9:0] ys;
    logic [1:0] us;
    xs = x[9:0];
    ys = y[9:0];
    us = u[1:0];
    return {xs, ys, mov, us};
  endfunction

  task automatic model_reset();
    m_x      = EX_X_INIT;
    m_y      = EX_Y_INIT;
    m_stable = '0;
    for (int b = 0; b < 4; b++) m_cnt[b] = 0;
  endtask

  // expected effect of one tick, using the levels accepted before it
  task automatic model_tick(input bit rc, input bit fr);
    int nx;
    int ny;
    bit chg;
    nx = m_x;
    ny = m_y;
    if (rc) begin
      nx = EX_X_INIT;
      ny = EX_Y_INIT;
    end else if (!fr) begin
      if (m_stable[BTN_RIGHT] && !m_stable[BTN_LEFT])
        nx = (m_x + EX_STEP > EX_X_MAX) ? EX_X_MAX : m_x + EX_STEP;
      else if (m_stable[BTN_LEFT] && !m_stable[BTN_RIGHT])
        nx = (m_x < EX_X_MIN + EX_STEP) ? EX_X_MIN : m_x - EX_STEP;
      if (m_stable[BTN_DOWN] && !m_stable[BTN_UP])
        ny = (m_y + EX_STEP > EX_Y_MAX) ? EX_Y_MAX : m_y + EX_STEP;
      else if (m_stable[BTN_UP] && !m_stable[BTN_DOWN])
        ny = (m_y < EX_Y_MIN + EX_STEP) ? EX_Y_MIN : m_y - EX_STEP;
    end
    chg = (nx != m_x) || (ny != m_y);
    exp_q.push_back(pack(nx, ny, chg && !rc && !fr, chg ? 1 : 0));
    m_x = nx;
    m_y = ny;
    for (int b = 0; b < 4; b++) begin
      if (btn[b] == m_stable[b]) m_cnt[b] = 0;
      else if (m_cnt[b] == EX_DEB - 1) begin
        m_stable[b] = btn[b];
        m_cnt[b]    = 0;
      end else m_cnt[b]++;
    end
  endtask

  task automatic pop_compare(input string tag, input int start);
    logic [22:0] e;
    check({tag, "_sb_nonempty"}, (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_pos_x"},  pos_x,  e[22:13]);
      check({tag, "_pos_y"},  pos_y,  e[12:3]);
      check({tag, "_moving"}, moving, e[2]);
      check({tag, "_update"}, upd_cnt - start, e[1:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // 16-clock tick period; recenter, if requested, lands on the tick_en cycle
  task automatic do_tick(input string tag, input bit rc);
    int start;
    @(negedge clk50);
    start = upd_cnt;
    model_tick(rc, freeze);
    tick400 = 1'b1;
    @(negedge clk50);
    tick400 = 1'b0;
    @(negedge clk50);
    recenter = rc;
    @(negedge clk50);
    recenter = 1'b0;
    repeat (12) @(negedge clk50);
    pop_compare(tag, start);
  endtask

  task automatic do_recenter(input string tag);
    int start;
    bit chg;
    @(negedge clk50);
    start = upd_cnt;
    chg = (m_x != EX_X_INIT) || (m_y != EX_Y_INIT);
    exp_q.push_back(pack(EX_X_INIT, EX_Y_INIT, 1'b0, chg ? 1 : 0));
    m_x = EX_X_INIT;
    m_y = EX_Y_INIT;
    recenter = 1'b1;
    @(negedge clk50);
    recenter = 1'b0;
    repeat (4) @(negedge clk50);
    pop_compare(tag, start);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk50);
    rst_n = 1'b0;
    #1;
    check({tag, "_pos_x"},  pos_x,  EX_X_INIT);
    check({tag, "_pos_y"},  pos_y,  EX_Y_INIT);
    check({tag, "_moving"}, moving, 0);
    check({tag, "_update"}, update, 0);
    model_reset();
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b1;
    tick400  = 1'b0;
    btn      = '0;
    freeze   = 1'b0;
    recenter = 1'b0;
    model_reset();

    do_reset("reset_init");

    // hold right: four ticks to accept, then +2 per tick
    btn[BTN_RIGHT] = 1'b1;
    repeat (9) do_tick("right_hold", 1'b0);

    // short up glitch must never be accepted
    btn[BTN_RIGHT] = 1'b0;
    btn[BTN_UP]    = 1'b1;
    repeat (2) do_tick("glitch_up", 1'b0);
    btn[BTN_UP] = 1'b0;
    repeat (5) do_tick("glitch_after", 1'b0);

    // drive x into the right bound and hold there
    btn[BTN_RIGHT] = 1'b1;
    for (int i = 0; i < 200 && m_x != EX_X_MAX; i++) do_tick("clamp_x", 1'b0);
    repeat (2) do_tick("pinned_x", 1'b0);

    // y to the bottom bound, then up through 241 to the centre line
    btn[BTN_RIGHT] = 1'b0;
    btn[BTN_DOWN]  = 1'b1;
    for (int i = 0; i < 200 && m_y != EX_Y_MAX; i++) do_tick("clamp_ymax", 1'b0);
    repeat (2) do_tick("pinned_ymax", 1'b0);
    btn[BTN_DOWN] = 1'b0;
    btn[BTN_UP]   = 1'b1;
    for (int i = 0; i < 200 && m_y != EX_Y_MIN; i++) do_tick("clamp_ymin", 1'b0);
    repeat (2) do_tick("pinned_ymin", 1'b0);

    // recenter between ticks, then opposing x buttons with up still held
    do_recenter("recenter_idle");
    btn[BTN_LEFT]  = 1'b1;
    btn[BTN_RIGHT] = 1'b1;
    repeat (8) do_tick("opposing", 1'b0);

    // recenter on the same cycle as a moving tick
    do_tick("recenter_on_tick", 1'b1);

    // freeze while buttons change underneath; first free tick moves
    freeze        = 1'b1;
    btn[BTN_UP]   = 1'b0;
    btn[BTN_LEFT] = 1'b0;
    repeat (10) do_tick("frozen", 1'b0);
    freeze = 1'b0;
    repeat (3) do_tick("unfrozen", 1'b0);

    // reset while right is held: re-accepted after the debounce delay
    do_reset("reset_mid");
    repeat (6) do_tick("after_reset", 1'b0);

    check("no_back_to_back_update", consec_cnt, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
